// File: rtl/pmod_jstk_spi_pkg.sv
// Shared definitions for the PmodJSTK SPI poller.
//   jstk_state_t   : top-level transaction FSM encoding
//   NUM_BYTES      : bytes exchanged per poll
//   LED_CMD_PREFIX : upper six bits of the first byte sent to the joystick
//   JOY_CENTRE     : reset value of both axes (cursor holds still)
//   tx_byte_for()  : byte sent at a given position in the transaction
package pmod_jstk_spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } jstk_state_t;

    localparam int         NUM_BYTES      = 5;
    localparam logic [5:0] LED_CMD_PREFIX = 6'b100000;
    localparam logic [9:0] JOY_CENTRE     = 10'd512;

    // Only the first byte carries the LED command; the rest are padding
    // that clocks the joystick's reply out.
    function automatic logic [7:0] tx_byte_for(input logic [2:0] idx,
                                               input logic [1:0] led);
        return (idx == 3'd0) ? {LED_CMD_PREFIX, led} : 8'h00;
    endfunction

endpackage

// File: rtl/pmod_jstk_spi_byte_shifter.sv
// Single-byte SPI mode-0 shift engine, MSB first.
//   clk, clr  : clock, asynchronous active-high reset
//   start     : request to shift tx_byte (accepted only while idle)
//   tx_byte   : byte to send, sampled on start
//   miso      : serial data from the slave
//   sclk      : SPI clock, idle low, SCLK_HALF clk cycles per half period
//   mosi      : serial data to the slave, changes only with sclk low
//   rx_byte   : byte received, complete when done is high
//   done      : one-cycle pulse in the last cycle of bit 0's high half
//
// Handshake: start is a single-cycle request issued by the owner only when
// no byte is in flight; the first low half begins the cycle after start, so
// a byte occupies exactly 16*SCLK_HALF cycles ending with the done cycle.
module pmod_jstk_spi_byte_shifter #(
    parameter int SCLK_HALF = 750
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rx_byte,
    output logic       done
);

    localparam int HALF_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCLK_HALF - 1);

    logic              busy;
    logic [HALF_W-1:0] half_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        tx_sh;   // remaining bits, next one at [7]

    assign done = busy && sclk && (half_cnt == HALF_LAST) && (bit_idx == 3'd0);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            busy     <= 1'b0;
            half_cnt <= '0;
            bit_idx  <= 3'd0;
            tx_sh    <= 8'h00;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            rx_byte  <= 8'h00;
        end else if (start) begin
            busy     <= 1'b1;
            half_cnt <= '0;
            bit_idx  <= 3'd7;
            tx_sh    <= {tx_byte[6:0], 1'b0};
            sclk     <= 1'b0;
            mosi     <= tx_byte[7];
        end else if (busy) begin
            if (half_cnt == HALF_LAST) begin
                half_cnt <= '0;
                if (!sclk) begin
                    // Rising edge: slave data has been stable for a full low half.
                    sclk    <= 1'b1;
                    rx_byte <= {rx_byte[6:0], miso};
                end else begin
                    // Falling edge: mosi moves together with sclk going low.
                    sclk <= 1'b0;
                    if (bit_idx == 3'd0) begin
                        busy <= 1'b0;
                        mosi <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx - 3'd1;
                        mosi    <= tx_sh[7];
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                    end
                end
            end else begin
                half_cnt <= half_cnt + HALF_W'(1);
            end
        end
    end

endmodule

// File: rtl/pmod_jstk_spi.sv
// Polls a PmodJSTK joystick over SPI once every POLL_PERIOD clk cycles.
//   clk, clr     : 100 MHz clock, asynchronous active-high reset
//   led          : LED request, latched when a transaction starts
//   miso         : joystick serial data
//   sclk, mosi   : SPI clock (idle low) and data to the joystick
//   ss           : slave select, active low
//   joy_x, joy_y : latest 10-bit axis values
//   btn          : latest buttons {trigger, btn2, btn1}
//   sample_valid : one-cycle pulse when joy_x/joy_y/btn update
//
// Outputs are only written on the cycle a full 5-byte exchange finishes;
// earlier bytes are parked in a separate receive buffer.
module pmod_jstk_spi
    import pmod_jstk_spi_pkg::*;
#(
    parameter int SCLK_HALF   = 750,
    parameter int SS_SETUP    = 1500,
    parameter int BYTE_GAP    = 1000,
    parameter int POLL_PERIOD = 1000000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] led,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       ss,
    output logic [9:0] joy_x,
    output logic [9:0] joy_y,
    output logic [2:0] btn,
    output logic       sample_valid
);

    // One counter width wide enough for the longest interval, so no counter
    // can wrap inside its state. SS_SETUP and BYTE_GAP are assumed >= 1.
    localparam int MAX_CNT =
        (POLL_PERIOD > SS_SETUP) ? ((POLL_PERIOD > BYTE_GAP) ? POLL_PERIOD : BYTE_GAP)
                                 : ((SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP);
    localparam int CNT_W = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_PERIOD - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BYTE_GAP - 1);
    localparam logic [2:0]       LAST_BYTE  = 3'(NUM_BYTES - 1);

    jstk_state_t      state, state_next;
    logic [CNT_W-1:0] poll_cnt;
    logic [CNT_W-1:0] phase_cnt;
    logic [2:0]       byte_cnt;
    logic [1:0]       led_q;
    logic             shift_start;
    logic             shift_done;
    logic [7:0]       shift_tx;
    logic [7:0]       rx_byte;

    // Receive buffer for bytes 0..3; byte 4 goes straight to btn on completion.
    logic [7:0] x_lo, y_lo;
    logic [1:0] x_hi, y_hi;

    pmod_jstk_spi_byte_shifter #(
        .SCLK_HALF (SCLK_HALF)
    ) u_shifter (
        .clk     (clk),
        .clr     (clr),
        .start   (shift_start),
        .tx_byte (shift_tx),
        .miso    (miso),
        .sclk    (sclk),
        .mosi    (mosi),
        .rx_byte (rx_byte),
        .done    (shift_done)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        shift_start = 1'b0;
        shift_tx    = 8'h00;
        case (state)
            IDLE: begin
                // Counter saturates, so an overdue poll starts at once.
                if (poll_cnt == POLL_LAST) state_next = SETUP;
            end
            SETUP: begin
                if (phase_cnt == SETUP_LAST) begin
                    state_next  = SHIFT;
                    shift_start = 1'b1;
                    shift_tx    = tx_byte_for(3'd0, led_q);
                end
            end
            SHIFT: begin
                if (shift_done) state_next = (byte_cnt == LAST_BYTE) ? DONE : GAP;
            end
            GAP: begin
                if (phase_cnt == GAP_LAST) begin
                    state_next  = SHIFT;
                    shift_start = 1'b1;
                    shift_tx    = tx_byte_for(byte_cnt + 3'd1, led_q);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Poll timer (start to start, runs in every state), interval timer,
    // byte sequencing and LED latch.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            poll_cnt  <= '0;
            phase_cnt <= '0;
            byte_cnt  <= 3'd0;
            led_q     <= 2'b00;
        end else begin
            if (state == IDLE && state_next == SETUP) begin
                poll_cnt <= '0;
                led_q    <= led;
            end else if (poll_cnt != POLL_LAST) begin
                poll_cnt <= poll_cnt + CNT_W'(1);
            end

            if (state_next != state)
                phase_cnt <= '0;
            else if (state == SETUP || state == GAP)
                phase_cnt <= phase_cnt + CNT_W'(1);

            if (state == IDLE)
                byte_cnt <= 3'd0;
            else if (state == GAP && state_next == SHIFT)
                byte_cnt <= byte_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            x_lo <= 8'h00;
            x_hi <= 2'b00;
            y_lo <= 8'h00;
            y_hi <= 2'b00;
        end else if (state == SHIFT && shift_done) begin
            case (byte_cnt)
                3'd0:    x_lo <= rx_byte;
                3'd1:    x_hi <= rx_byte[1:0];
                3'd2:    y_lo <= rx_byte;
                3'd3:    y_hi <= rx_byte[1:0];
                default: ;
            endcase
        end
    end

    // ss is registered from the next state so it tracks the FSM exactly and
    // goes high immediately on clr. Outputs are written on entry to DONE so
    // they change in the same cycle sample_valid is high.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ss           <= 1'b1;
            joy_x        <= JOY_CENTRE;
            joy_y        <= JOY_CENTRE;
            btn          <= 3'b000;
            sample_valid <= 1'b0;
        end else begin
            ss <= !(state_next == SETUP || state_next == SHIFT || state_next == GAP);
            if (state == SHIFT && state_next == DONE) begin
                joy_x        <= {x_hi, x_lo};
                joy_y        <= {y_hi, y_lo};
                btn          <= rx_byte[2:0];
                sample_valid <= 1'b1;
            end else begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pmod_jstk_spi.md
Name: pmod_jstk_spi

Overview:
- SPI master that polls a PmodJSTK joystick module at a fixed rate.
- Produces the 10-bit joy_x/joy_y axis values and button states consumed by the cursor-update stage.
- Drives the module's two LEDs.
- Output registers change only on a complete, successful 5-byte transaction.

Parameters:
- SCLK_HALF, 750: clk cycles per SCLK half-period (66.7 kHz at 100 MHz).
- SS_SETUP, 1500: clk cycles between ss falling and the first SCLK rising half (15 us).
- BYTE_GAP, 1000: clk cycles between bytes, ss held low (10 us).
- POLL_PERIOD, 1000000: clk cycles between transaction starts (10 ms).

Ports:
- clk  in  1  system clock, 100 MHz.
- clr  in  1  asynchronous reset, active-high.
- led  in  2  LED request, sampled at transaction start.
- miso  in  1  joystick serial data.
- sclk  out  1  SPI clock, idle low.
- mosi  out  1  SPI data to joystick.
- ss  out  1  slave select, active-low.
- joy_x  out  10  latest X axis value.
- joy_y  out  10  latest Y axis value.
- btn  out  3  latest buttons {trigger, btn2, btn1}.
- sample_valid  out  1  one-cycle pulse when joy_x/joy_y/btn update.

Behaviour:
- Reset is asynchronous on clr, active-high, clocked by clk. Reset values: joy_x=512, joy_y=512 (centre, inside the downstream 400..600 dead zone, so the cursor holds still), btn=0, sample_valid=0, ss=1, sclk=0, mosi=0, state=IDLE, all counters 0.
- SPI is mode 0, MSB first. mosi changes only while sclk is low. miso is registered in the clk cycle in which sclk rises.
- FSM states:
  - IDLE: ss=1. The poll counter counts to POLL_PERIOD-1, then goes to SETUP, latches led, loads tx byte.
  - SETUP: ss=0, sclk=0. Stays SS_SETUP cycles, then goes to SHIFT with bit index 7.
  - SHIFT: each bit is SCLK_HALF cycles low (mosi valid), then SCLK_HALF cycles high. After bit 0 high half, sclk returns low. Byte count 0..3 goes to GAP; byte count 4 goes to DONE.
  - GAP: ss=0, sclk=0. Stays BYTE_GAP cycles, increments byte count, loads next tx byte, goes to SHIFT.
  - DONE: one cycle. ss=1, joy_x/joy_y/btn written from the rx buffer, sample_valid=1, then IDLE.
- TX bytes: byte0 = {6'b100000, led_latched}; bytes 1-4 = 8'h00.
- RX byte mapping:
  - rx0 = X[7:0]
  - rx1[1:0] = X[9:8]
  - rx2 = Y[7:0]
  - rx3[1:0] = Y[9:8]
  - rx4[2:0] = btn
  - Upper unused bits are ignored.
- Transaction length: ss low for SS_SETUP + 80*SCLK_HALF + 4*BYTE_GAP cycles. sample_valid fires in the following DONE cycle.
- Poll period is measured start to start, and the poll counter runs in all states. If POLL_PERIOD is shorter than the transaction, the next start occurs on the first IDLE cycle.
- Partial data is never visible on the outputs. The rx buffer is separate from the output registers.
- clr mid-transaction: ss goes high and sclk low immediately (asynchronous). The partial buffer is discarded and outputs return to reset values.
- led changes during a transaction take effect at the next transaction.
- Counters are sized to hold POLL_PERIOD-1 and must not wrap within a state.

Decomposition:
- Shared include jstk_defs.vh holds:
  - state encodings IDLE/SETUP/SHIFT/GAP/DONE
  - NUM_BYTES=5
  - LED_CMD_PREFIX=6'b100000
  - JOY_CENTRE=10'd512
- One natural sub-module, spi_byte_shifter: an 8-bit mode-0 shift engine with a SCLK_HALF divider, start/done handshake, tx_byte in, rx_byte out. The top level holds the FSM, byte sequencing, poll timer and output registers.

Test Plan:
Bench setup: SCLK_HALF=2, SS_SETUP=4, BYTE_GAP=3, POLL_PERIOD=300, with a behavioural PmodJSTK slave model.
- Reset only: joy_x=512, joy_y=512, btn=0, ss=1, sclk=0. No sclk edges before cycle 299.
- Slave returns X=10'h3A5, Y=10'h04C, btn=3'b101:
  - exactly 40 sclk rising edges;
  - sample_valid single pulse 176 cycles after ss falls;
  - joy_x=933, joy_y=76, btn=5.
- led=2'b10: slave captures first mosi byte 8'h82 and bytes 1-4 as 8'h00. Toggling led mid-transfer does not change the current byte0.
- Mode check: the slave monitor asserts mosi stable whenever sclk is high, and sees zero sclk edges during each 3-cycle GAP and the 4-cycle SETUP.
- Pulse clr during byte 2, after one valid sample X=100:
  - ss rises the same cycle;
  - outputs return to 512/512/0;
  - no sample_valid until the next full transaction, which restarts at byte0.
- Back-to-back polls with X changing 0 -> 1023: transaction starts are 300 cycles apart. joy_x holds 0 until the second DONE cycle, then becomes 1023.
